nocif_dram_write_os_arb: RTL and testbench
==========================================

Name: nocif_dram_write_os_arb

Overview:
- Round-robin arbiter and outstanding-credit scheduler for the NOCIF DRAM write request path.
- Shares the single AXI write-request issue slot among NUM_CLIENTS DMA write clients.
- Charges each granted request (len+1) credits against a programmable outstanding limit.
- Refunds credits from the egress write-response return (eg2ig_axi_vld / eg2ig_axi_len).
- Provides a quiesce handshake so software can drain all write traffic before reconfiguration.

Parameters:
- NUM_CLIENTS, 5, number of write requesters (1..8).
- OS_CNT_W, 9, width of the outstanding-credit counter and of the limit.
- ID_W, 3, width of the client id emitted with each grant.

Ports:
- nvdla_core_clk  input  1  core clock; all logic is on its rising edge.
- nvdla_core_rst  input  1  reset, synchronous, active-high.
- cl_req_vld  input  NUM_CLIENTS  per-client request valid.
- cl_req_len  input  2*NUM_CLIENTS  per-client burst length minus 1; client i uses bits [2i+1:2i].
- cl_req_rdy  output  NUM_CLIENTS  per-client accept; one-hot or zero.
- arb_out_vld  output  1  registered granted request valid.
- arb_out_id  output  ID_W  client index of the granted request.
- arb_out_len  output  2  length of the granted request.
- arb_out_rdy  input  1  downstream accept.
- eg2ig_axi_vld  input  1  write response retired.
- eg2ig_axi_len  input  2  length of the retired request.
- reg_os_limit  input  OS_CNT_W  maximum outstanding credits.
- quiesce_req  input  1  level request to stop issuing and drain.
- quiesce_ack  output  1  high while drained.
- os_cnt  output  OS_CNT_W  current outstanding credits.
- os_underflow  output  1  sticky error flag.

Behaviour:
- Reset values: arb_out_vld=0, arb_out_id=0, arb_out_len=0, os_cnt=0, os_underflow=0, quiesce_ack=0, RR pointer=0, FSM=RUN.
- The output stage is a single register. It can load when empty or when arb_out_vld&arb_out_rdy in the same cycle (load_en).
- Eligibility: elig[i] = cl_req_vld[i] & (os_cnt + len_i + 1 <= reg_os_limit).
  - The compare is done at OS_CNT_W+1 bits; no wrap.
  - os_cnt here is the pre-update value for the current cycle.
- Grant rules:
  - A grant is issued only when FSM=RUN and load_en is high.
  - The winner is the first elig bit at or after the RR pointer, searching upward with wrap.
  - cl_req_rdy[winner]=1, combinational, same cycle.
  - The output register loads {id,len} on the next edge.
  - The RR pointer moves to winner+1; it wraps from NUM_CLIENTS-1 to 0.
  - With no grant, the pointer holds.
- Latency: request to arb_out_vld is 1 cycle. Back-to-back grants are allowed every cycle while arb_out_rdy=1.
- Credit accounting, applied each cycle:
  - os_cnt_next = os_cnt + grant*(len+1) - eg2ig_axi_vld*(eg2ig_axi_len+1).
  - A simultaneous grant and return nets out.
  - If a return exceeds os_cnt plus the grant charge, os_cnt saturates to 0 and os_underflow sets.
  - os_underflow clears only on reset.
- Ineligible clients are skipped. A large request that does not fit does not block smaller fitting requests from other clients.
- If reg_os_limit is 0, or is lowered below os_cnt: no grants; returns continue to decrement os_cnt. Changing the limit never alters os_cnt.
- FSM:
  - RUN: grants enabled. quiesce_req=1 -> DRAIN.
  - DRAIN: no grants; a pending output register still drains. When arb_out_vld=0 and os_cnt=0 -> QUIESCED.
  - QUIESCED: quiesce_ack=1 (registered, asserted in the cycle after entry). quiesce_req=0 -> RUN, ack drops in the same transition.
  - quiesce_req deasserted while in DRAIN -> RUN directly; ack is never asserted.
- Reset asserted mid-operation discards the output register and os_cnt. In-flight responses returning after reset set os_underflow by design.

Optional Feature:
- Macro: NOCIF_WR_OS_STALL_CNT_EN.
- When defined:
  - Adds output credit_stall_cnt [15:0].
  - Increments by 1 each cycle FSM=RUN, load_en=1, |cl_req_vld=1 and no client is eligible.
  - Saturates at 16'hFFFF and clears on reset.
- When undefined: the port and counter are absent; the other behaviour is unchanged.

Test Plan:
- Limit=16, clients 0,2,4 request len=3 continuously, arb_out_rdy=1 -> grant order 0,2,4,0; os_cnt reaches 16 after 4 grants; 5th grant blocked until eg2ig_axi_vld len=3 returns, then os_cnt=12 and the grant resumes next cycle.
- Limit=5, os_cnt=3, client0 len=3 and client1 len=0 both valid, pointer=0 -> client0 skipped, client1 granted, os_cnt=4.
- Same-cycle grant len=1 and return len=2 at os_cnt=6 -> os_cnt=5; os_cnt=1 with return len=3 and no grant -> os_cnt=0, os_underflow=1.
- arb_out_rdy held 0 for 4 cycles with all clients valid -> arb_out_vld/id stable, cl_req_rdy=0, os_cnt unchanged; rdy=1 -> next grant loads the same cycle.
- quiesce_req=1 with os_cnt=8 -> no further cl_req_rdy; after returns bring os_cnt to 0 and arb_out_vld=0, quiesce_ack=1 next cycle; quiesce_req=0 -> ack=0 and grants resume.
- Limit=0 with requests pending for 10 cycles (macro on) -> no grants, credit_stall_cnt=10.

Source files
------------

// File: rtl/nocif_dram_write_os_arb.sv
// Round-robin write-request arbiter with outstanding-credit limiting and a quiesce handshake.
// Optional NOCIF_WR_OS_STALL_CNT_EN adds credit_stall_cnt (cycles lost to credit starvation).
module nocif_dram_write_os_arb #(
  parameter int NUM_CLIENTS = 5,
  parameter int OS_CNT_W    = 9,
  parameter int ID_W        = 3
) (
  input  logic                     nvdla_core_clk,
  input  logic                     nvdla_core_rst,
  input  logic [NUM_CLIENTS-1:0]   cl_req_vld,
  input  logic [2*NUM_CLIENTS-1:0] cl_req_len,
  output logic [NUM_CLIENTS-1:0]   cl_req_rdy,
  output logic                     arb_out_vld,
  output logic [ID_W-1:0]          arb_out_id,
  output logic [1:0]               arb_out_len,
  input  logic                     arb_out_rdy,
  input  logic                     eg2ig_axi_vld,
  input  logic [1:0]               eg2ig_axi_len,
  input  logic [OS_CNT_W-1:0]      reg_os_limit,
  input  logic                     quiesce_req,
  output logic                     quiesce_ack,
  output logic [OS_CNT_W-1:0]      os_cnt,
  output logic                     os_underflow,
`ifdef NOCIF_WR_OS_STALL_CNT_EN
  output logic [15:0]              credit_stall_cnt,
`endif
  output logic [1:0]               dbg_state
);

  localparam int CW = OS_CNT_W + 1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_QUIESCED = 2'd2
  } state_e;

  // Handshake: a client request transfers when cl_req_vld[i] & cl_req_rdy[i];
  // the output stage transfers when arb_out_vld & arb_out_rdy.
  state_e                   state_q, state_d;
  logic [ID_W-1:0]          ptr_q, ptr_d;
  logic                     out_vld_q, out_vld_d;
  logic [ID_W-1:0]          out_id_q, out_id_d;
  logic [1:0]               out_len_q, out_len_d;
  logic [OS_CNT_W-1:0]      os_cnt_q, os_cnt_d;
  logic                     uf_q, uf_d;
  logic                     ack_q, ack_d;

  logic [NUM_CLIENTS-1:0]   elig;
  logic                     load_en;
  logic                     grant;
  logic                     found;
  logic [ID_W-1:0]          win_id;
  logic [1:0]               win_len;
  logic [CW-1:0]            charge, refund, sum;

  assign load_en = ~out_vld_q | arb_out_rdy;

  // Compare at CW bits so os_cnt + len + 1 can never wrap past the limit.
  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      elig[i] = cl_req_vld[i] &
                (({1'b0, os_cnt_q} + CW'(cl_req_len[2*i +: 2]) + CW'(1)) <= {1'b0, reg_os_limit});
    end
  end

  always_comb begin
    int idx;
    found   = 1'b0;
    win_id  = '0;
    win_len = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      if (!found && elig[idx]) begin
        found   = 1'b1;
        win_id  = ID_W'(idx);
        win_len = cl_req_len[2*idx +: 2];
      end
    end
  end

  assign grant      = (state_q == ST_RUN) & load_en & found;
  assign cl_req_rdy = grant ? (NUM_CLIENTS'(1) << win_id) : '0;

  always_comb begin
    ptr_d     = ptr_q;
    out_vld_d = out_vld_q;
    out_id_d  = out_id_q;
    out_len_d = out_len_q;
    if (load_en) begin
      out_vld_d = grant;
      if (grant) begin
        out_id_d  = win_id;
        out_len_d = win_len;
      end
    end
    if (grant) begin
      ptr_d = (int'(win_id) == NUM_CLIENTS - 1) ? '0 : ID_W'(int'(win_id) + 1);
    end
  end

  // Net the grant charge and the response refund; an excess refund saturates at 0.
  always_comb begin
    charge   = grant ? (CW'(win_len) + CW'(1)) : '0;
    refund   = eg2ig_axi_vld ? (CW'(eg2ig_axi_len) + CW'(1)) : '0;
    sum      = {1'b0, os_cnt_q} + charge;
    uf_d     = uf_q;
    os_cnt_d = os_cnt_q;
    if (refund > sum) begin
      os_cnt_d = '0;
      uf_d     = 1'b1;
    end else begin
      os_cnt_d = OS_CNT_W'(sum - refund);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (quiesce_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!quiesce_req)                         state_d = ST_RUN;
        else if (!out_vld_q && (os_cnt_q == '0)) state_d = ST_QUIESCED;
      end
      ST_QUIESCED: if (!quiesce_req) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
    ack_d = (state_d == ST_QUIESCED);
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q   <= ST_RUN;
      ptr_q     <= '0;
      out_vld_q <= 1'b0;
      out_id_q  <= '0;
      out_len_q <= '0;
      os_cnt_q  <= '0;
      uf_q      <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      out_vld_q <= out_vld_d;
      out_id_q  <= out_id_d;
      out_len_q <= out_len_d;
      os_cnt_q  <= os_cnt_d;
      uf_q      <= uf_d;
      ack_q     <= ack_d;
    end
  end

`ifdef NOCIF_WR_OS_STALL_CNT_EN
  logic [15:0] stall_q;
  logic        stall_inc;

  assign stall_inc = (state_q == ST_RUN) & load_en & (|cl_req_vld) & ~(|elig);

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst)                      stall_q <= '0;
    else if (stall_inc && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end

  assign credit_stall_cnt = stall_q;
`endif

  assign arb_out_vld  = out_vld_q;
  assign arb_out_id   = out_id_q;
  assign arb_out_len  = out_len_q;
  assign os_cnt       = os_cnt_q;
  assign os_underflow = uf_q;
  assign quiesce_ack  = ack_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_nocif_dram_write_os_arb.sv
// Directed bench for nocif_dram_write_os_arb: per-cycle vector table plus hand-written corner sequences.
module tb_nocif_dram_write_os_arb;

  logic       clk;
  logic       rst;
  logic [4:0] cl_req_vld;
  logic [9:0] cl_req_len;
  logic [4:0] cl_req_rdy;
  logic       arb_out_vld;
  logic [2:0] arb_out_id;
  logic [1:0] arb_out_len;
  logic       arb_out_rdy;
  logic       eg_vld;
  logic [1:0] eg_len;
  logic [8:0] os_limit;
  logic       quiesce_req;
  logic       quiesce_ack;
  logic [8:0] os_cnt;
  logic       os_underflow;
  logic [1:0] dbg_state;
`ifdef NOCIF_WR_OS_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  nocif_dram_write_os_arb dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .cl_req_vld     (cl_req_vld),
    .cl_req_len     (cl_req_len),
    .cl_req_rdy     (cl_req_rdy),
    .arb_out_vld    (arb_out_vld),
    .arb_out_id     (arb_out_id),
    .arb_out_len    (arb_out_len),
    .arb_out_rdy    (arb_out_rdy),
    .eg2ig_axi_vld  (eg_vld),
    .eg2ig_axi_len  (eg_len),
    .reg_os_limit   (os_limit),
    .quiesce_req    (quiesce_req),
    .quiesce_ack    (quiesce_ack),
    .os_cnt         (os_cnt),
    .os_underflow   (os_underflow),
`ifdef NOCIF_WR_OS_STALL_CNT_EN
    .credit_stall_cnt (stall_cnt),
`endif
    .dbg_state      (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       qr;
    logic [8:0] lim;
    logic [4:0] vld;
    logic [9:0] len;
    logic       ordy;
    logic       egv;
    logic [1:0] egl;
    logic [4:0] e_rdy;
    logic       e_vld;
    logic [2:0] e_id;
    logic [1:0] e_len;
    logic [8:0] e_os;
    logic       e_uf;
    logic       e_ack;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input logic r, input logic qr, input logic [8:0] lim,
                            input logic [4:0] vld, input logic [9:0] len, input logic ordy,
                            input logic egv, input logic [1:0] egl,
                            input logic [4:0] e_rdy, input logic e_vld, input logic [2:0] e_id,
                            input logic [1:0] e_len, input logic [8:0] e_os,
                            input logic e_uf, input logic e_ack);
    vec_t t;
    t.rst = r;  t.qr = qr; t.lim = lim; t.vld = vld; t.len = len; t.ordy = ordy;
    t.egv = egv; t.egl = egl; t.e_rdy = e_rdy; t.e_vld = e_vld; t.e_id = e_id;
    t.e_len = e_len; t.e_os = e_os; t.e_uf = e_uf; t.e_ack = e_ack;
    vecs.push_back(t);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_idle();
    cl_req_vld  = '0;
    cl_req_len  = '0;
    arb_out_rdy = 1'b0;
    eg_vld      = 1'b0;
    eg_len      = '0;
    os_limit    = '0;
    quiesce_req = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    // Scenario 1: limit 16, clients 0/2/4 len 3, credit exhaustion and refund
    v(0,0,16,5'b10101,10'h3FF,1,0,0, 5'b00001,0,0,0, 0,0,0);
    v(0,0,16,5'b10101,10'h3FF,1,0,0, 5'b00100,1,0,3, 4,0,0);
    v(0,0,16,5'b10101,10'h3FF,1,0,0, 5'b10000,1,2,3, 8,0,0);
    v(0,0,16,5'b10101,10'h3FF,1,0,0, 5'b00001,1,4,3,12,0,0);
    v(0,0,16,5'b10101,10'h3FF,1,0,0, 5'b00000,1,0,3,16,0,0);
    v(0,0,16,5'b10101,10'h3FF,1,1,3, 5'b00000,0,0,0,16,0,0);
    v(0,0,16,5'b10101,10'h3FF,1,0,0, 5'b00100,0,0,0,12,0,0);
    v(0,0,16,5'b10101,10'h3FF,1,0,0, 5'b00000,1,2,3,16,0,0);
    v(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
    // Scenario 2/3: skip of non-fitting client, netting, underflow
    v(0,0,5, 5'b10000,10'h200,1,0,0, 5'b10000,0,0,0, 0,0,0);
    v(0,0,5, 5'b00011,10'h003,1,0,0, 5'b00010,1,4,2, 3,0,0);
    v(0,0,16,5'b00001,10'h001,1,0,0, 5'b00001,1,1,0, 4,0,0);
    v(0,0,16,5'b00001,10'h001,1,1,2, 5'b00001,1,0,1, 6,0,0);
    v(0,0,16,5'b00000,10'h000,1,0,0, 5'b00000,1,0,1, 5,0,0);
    v(0,0,16,5'b00000,10'h000,1,1,3, 5'b00000,0,0,0, 5,0,0);
    v(0,0,16,5'b00000,10'h000,1,1,3, 5'b00000,0,0,0, 1,0,0);
    v(0,0,16,5'b00000,10'h000,1,0,0, 5'b00000,0,0,0, 0,1,0);
    v(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
    // Scenario 4: downstream backpressure for 4 cycles
    v(0,0,16,5'b11111,10'h000,1,0,0, 5'b00001,0,0,0, 0,0,0);
    for (int i = 0; i < 4; i++)
      v(0,0,16,5'b11111,10'h000,0,0,0, 5'b00000,1,0,0, 1,0,0);
    v(0,0,16,5'b11111,10'h000,1,0,0, 5'b00010,1,0,0, 1,0,0);
    v(0,0,16,5'b00000,10'h000,1,0,0, 5'b00000,1,1,0, 2,0,0);
    v(0,0,16,5'b00000,10'h000,1,0,0, 5'b00000,0,0,0, 2,0,0);
    v(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
    // Scenario 5: quiesce with credits outstanding
    v(0,0,8, 5'b00001,10'h003,1,0,0, 5'b00001,0,0,0, 0,0,0);
    v(0,0,8, 5'b00001,10'h003,1,0,0, 5'b00001,1,0,3, 4,0,0);
    v(0,1,8, 5'b00001,10'h000,1,0,0, 5'b00000,1,0,3, 8,0,0);
    v(0,1,16,5'b00001,10'h003,1,0,0, 5'b00000,0,0,0, 8,0,0);
    v(0,1,16,5'b00001,10'h003,1,1,3, 5'b00000,0,0,0, 8,0,0);
    v(0,1,16,5'b00001,10'h003,1,1,3, 5'b00000,0,0,0, 4,0,0);
    v(0,1,16,5'b00001,10'h003,1,0,0, 5'b00000,0,0,0, 0,0,0);
    v(0,1,16,5'b00001,10'h003,1,0,0, 5'b00000,0,0,0, 0,0,1);
    v(0,0,16,5'b00001,10'h003,1,0,0, 5'b00000,0,0,0, 0,0,1);
    v(0,0,16,5'b00001,10'h003,1,0,0, 5'b00001,0,0,0, 0,0,0);
    v(0,0,16,5'b00000,10'h000,1,0,0, 5'b00000,1,0,3, 4,0,0);
    v(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
    // Scenario 6: quiesce withdrawn during drain
    v(0,0,16,5'b00001,10'h000,1,0,0, 5'b00001,0,0,0, 0,0,0);
    v(0,1,16,5'b00000,10'h000,1,0,0, 5'b00000,1,0,0, 1,0,0);
    v(0,1,16,5'b00000,10'h000,1,0,0, 5'b00000,0,0,0, 1,0,0);
    v(0,0,16,5'b00010,10'h000,1,0,0, 5'b00000,0,0,0, 1,0,0);
    v(0,0,16,5'b00010,10'h000,1,0,0, 5'b00010,0,0,0, 1,0,0);
    v(0,0,16,5'b00000,10'h000,1,0,0, 5'b00000,1,1,0, 2,0,0);

    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_vld", 32'(arb_out_vld), 32'd0);
    check("reset_id", 32'(arb_out_id), 32'd0);
    check("reset_len", 32'(arb_out_len), 32'd0);
    check("reset_os", 32'(os_cnt), 32'd0);
    check("reset_uf", 32'(os_underflow), 32'd0);
    check("reset_ack", 32'(quiesce_ack), 32'd0);
    next_cycle();

    foreach (vecs[n]) begin
      rst         = vecs[n].rst;
      quiesce_req = vecs[n].qr;
      os_limit    = vecs[n].lim;
      cl_req_vld  = vecs[n].vld;
      cl_req_len  = vecs[n].len;
      arb_out_rdy = vecs[n].ordy;
      eg_vld      = vecs[n].egv;
      eg_len      = vecs[n].egl;
      @(negedge clk);
      if (!vecs[n].rst) begin
        check($sformatf("vec%0d_rdy", n), 32'(cl_req_rdy), 32'(vecs[n].e_rdy));
        check($sformatf("vec%0d_vld", n), 32'(arb_out_vld), 32'(vecs[n].e_vld));
        if (vecs[n].e_vld) begin
          check($sformatf("vec%0d_id", n), 32'(arb_out_id), 32'(vecs[n].e_id));
          check($sformatf("vec%0d_len", n), 32'(arb_out_len), 32'(vecs[n].e_len));
        end
        check($sformatf("vec%0d_os", n), 32'(os_cnt), 32'(vecs[n].e_os));
        check($sformatf("vec%0d_uf", n), 32'(os_underflow), 32'(vecs[n].e_uf));
        check($sformatf("vec%0d_ack", n), 32'(quiesce_ack), 32'(vecs[n].e_ack));
      end
      next_cycle();
    end
    rst = 1'b0;

    // Reset mid-operation: in-flight response after reset flags underflow
    do_reset();
    os_limit = 16; arb_out_rdy = 1'b1; cl_req_vld = 5'b00001; cl_req_len = 10'h003;
    next_cycle();
    cl_req_vld = '0; rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_os", 32'(os_cnt), 32'd0);
    check("midrst_vld", 32'(arb_out_vld), 32'd0);
    check("midrst_uf", 32'(os_underflow), 32'd0);
    eg_vld = 1'b1; eg_len = 2'd0;
    next_cycle();
    eg_vld = 1'b0;
    @(negedge clk);
    check("late_resp_os", 32'(os_cnt), 32'd0);
    check("late_resp_uf", 32'(os_underflow), 32'd1);

    // Limit lowered below os_cnt: grants stop, os_cnt untouched, returns still refund
    do_reset();
    os_limit = 16; arb_out_rdy = 1'b1; cl_req_vld = 5'b00001; cl_req_len = 10'h003;
    next_cycle();
    os_limit = 2; cl_req_vld = 5'b00011; cl_req_len = 10'h000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("lowlim%0d_rdy", c), 32'(cl_req_rdy), 32'd0);
      check($sformatf("lowlim%0d_os", c), 32'(os_cnt), 32'd4);
      next_cycle();
    end
    eg_vld = 1'b1; eg_len = 2'd1;
    next_cycle();
    eg_vld = 1'b0;
    @(negedge clk);
    check("lowlim_refund_os", 32'(os_cnt), 32'd2);
    check("lowlim_refund_rdy", 32'(cl_req_rdy), 32'd0);
    os_limit = 3;
    #1;
    check("lowlim_raise_rdy", 32'(cl_req_rdy), 32'b00010);
    next_cycle();

`ifdef NOCIF_WR_OS_STALL_CNT_EN
    // Zero limit: every requesting cycle counts as a credit stall
    do_reset();
    os_limit = 0; arb_out_rdy = 1'b1; cl_req_vld = 5'b11111; cl_req_len = 10'h000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d_rdy", c), 32'(cl_req_rdy), 32'd0);
      next_cycle();
    end
    @(negedge clk);
    check("stall_cnt", 32'(stall_cnt), 32'd10);
    check("stall_os", 32'(os_cnt), 32'd0);
    cl_req_vld = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
